// File: rtl/i2c_arbiter.sv
`timescale 1ns/1ps
// i2c_arbiter
// Shares one I2C master driver between two clients (port 0: AD/DA, port 1: EEPROM/RTC).
// Each client sees a private-driver style exec/done handshake. Grants are round-robin.
// Each port has its own slave address and word-address width. A watchdog aborts a hung transfer.
module i2c_arbiter #(
    parameter logic [6:0]  SLV_ADDR0  = 7'h48,
    parameter logic [6:0]  SLV_ADDR1  = 7'h50,
    parameter logic        BIT_CTRL0  = 1'b0,
    parameter logic        BIT_CTRL1  = 1'b1,
    parameter logic [19:0] TIMEOUT    = 20'd100000,
    parameter logic [7:0]  GAP_CYCLES = 8'd4
) (
    input  logic        clk_i2c_arb,
    input  logic        rst_n,
    input  logic        req0_exec,
    input  logic        req0_rh_wl,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_data_w,
    output logic [7:0]  req0_data_r,
    output logic        req0_done,
    output logic        req0_err,
    output logic        req0_busy,
    input  logic        req1_exec,
    input  logic        req1_rh_wl,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_data_w,
    output logic [7:0]  req1_data_r,
    output logic        req1_done,
    output logic        req1_err,
    output logic        req1_busy,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    output logic [6:0]  i2c_slave_addr,
    output logic        i2c_bit_ctrl,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    // Last WAIT_DONE count value; reaching it without i2c_done aborts the transfer.
    localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd1;

    // Client inputs gathered into per-port arrays so both ports share one code path.
    logic [1:0]  w_exec;
    logic [1:0]  w_rh_wl;
    logic [15:0] w_addr   [2];
    logic [7:0]  w_data_w [2];

    assign w_exec      = {req1_exec, req0_exec};
    assign w_rh_wl     = {req1_rh_wl, req0_rh_wl};
    assign w_addr[0]   = req0_addr;
    assign w_addr[1]   = req1_addr;
    assign w_data_w[0] = req0_data_w;
    assign w_data_w[1] = req1_data_w;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_pend;
    logic [1:0]  r_rh_wl;
    logic [15:0] r_addr   [2];
    logic [7:0]  r_data_w [2];
    logic        r_cur;
    logic        r_last;
    logic [19:0] r_tcnt;
    logic [7:0]  r_gcnt;
    logic        r_i2c_rh_wl;
    logic [15:0] r_i2c_addr;
    logic [7:0]  r_i2c_data_w;
    logic [6:0]  r_i2c_slave;
    logic        r_i2c_bc;
    logic [1:0]  r_done;
    logic [1:0]  r_err;
    logic [7:0]  r_data_r [2];
    logic        w_load;
    logic        w_fin;
    logic        w_tout;
    logic        w_win;

    // Request capture: latch a client's fields on exec while idle; release one cycle after its done.
    // NOTE: sequential state is written with non-blocking assignments so every register samples
    // pre-edge values; blocking here would let one register see another's new value in the same edge.
    // NOTE: these per-port field arrays are a handful of flops, not a RAM, so resetting them is cheap
    // and keeps every output deterministic straight out of reset.
    always_ff @(posedge clk_i2c_arb or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 2'b00;
            r_rh_wl <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_addr[i]   <= 16'h0000;
                r_data_w[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_exec[i] && !r_pend[i]) begin
                    r_pend[i]   <= 1'b1;
                    r_rh_wl[i]  <= w_rh_wl[i];
                    r_addr[i]   <= w_addr[i];
                    r_data_w[i] <= w_data_w[i];
                end else if (r_done[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i2c_arb or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and control strobes: pick a winner, detect completion or watchdog expiry.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fin       = 1'b0;
        w_tout      = 1'b0;
        // On a tie the port that was not served last wins; otherwise the only pending port wins.
        w_win       = (r_pend == 2'b11) ? ~r_last : r_pend[1];
        case (r_state)
            IDLE: begin
                if (|r_pend) begin
                    w_load      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (i2c_done) begin
                    w_fin       = 1'b1;
                    w_state_nxt = GAP;
                end else if (r_tcnt >= TMO_LAST) begin
                    w_fin       = 1'b1;
                    w_tout      = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                // GAP always lasts at least one cycle, even with GAP_CYCLES = 0.
                if (({1'b0, r_gcnt} + 9'd1) >= {1'b0, GAP_CYCLES}) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and the driver fields, held stable from ISSUE until the next grant.
    always_ff @(posedge clk_i2c_arb or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= 1'b0;
            r_last       <= 1'b1;
            r_i2c_rh_wl  <= 1'b0;
            r_i2c_addr   <= 16'h0000;
            r_i2c_data_w <= 8'h00;
            r_i2c_slave  <= 7'h00;
            r_i2c_bc     <= 1'b0;
        end else begin
            if (w_load) begin
                r_cur        <= w_win;
                r_i2c_rh_wl  <= r_rh_wl[w_win];
                r_i2c_addr   <= r_addr[w_win];
                r_i2c_data_w <= r_data_w[w_win];
                r_i2c_slave  <= w_win ? SLV_ADDR1 : SLV_ADDR0;
                r_i2c_bc     <= w_win ? BIT_CTRL1 : BIT_CTRL0;
            end
            if (w_fin) r_last <= r_cur;
        end
    end

    // Watchdog: zero in ISSUE, counts through ISSUE/WAIT_DONE, saturates instead of wrapping.
    always_ff @(posedge clk_i2c_arb or negedge rst_n) begin
        if (!rst_n)                                                          r_tcnt <= 20'd0;
        else if (w_load)                                                     r_tcnt <= 20'd0;
        else if ((r_state == ISSUE || r_state == WAIT_DONE) && r_tcnt != '1) r_tcnt <= r_tcnt + 20'd1;
    end

    // Inter-transfer gap counter.
    always_ff @(posedge clk_i2c_arb or negedge rst_n) begin
        if (!rst_n)              r_gcnt <= 8'd0;
        else if (w_fin)          r_gcnt <= 8'd0;
        else if (r_state == GAP) r_gcnt <= r_gcnt + 8'd1;
    end

    // Client responses: one-cycle done, sticky err, read data (0xFF on abort, held on write).
    always_ff @(posedge clk_i2c_arb or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 2'b00;
            r_err       <= 2'b00;
            r_data_r[0] <= 8'h00;
            r_data_r[1] <= 8'h00;
        end else begin
            r_done <= 2'b00;
            if (w_fin) begin
                r_done[r_cur] <= 1'b1;
                r_err[r_cur]  <= w_tout;
                if (w_tout)           r_data_r[r_cur] <= 8'hFF;
                else if (r_i2c_rh_wl) r_data_r[r_cur] <= i2c_data_r;
            end
        end
    end

    assign req0_data_r    = r_data_r[0];
    assign req0_done      = r_done[0];
    assign req0_err       = r_err[0];
    assign req0_busy      = r_pend[0];
    assign req1_data_r    = r_data_r[1];
    assign req1_done      = r_done[1];
    assign req1_err       = r_err[1];
    assign req1_busy      = r_pend[1];
    assign i2c_exec       = (r_state == ISSUE);
    assign i2c_rh_wl      = r_i2c_rh_wl;
    assign i2c_addr       = r_i2c_addr;
    assign i2c_data_w     = r_i2c_data_w;
    assign i2c_slave_addr = r_i2c_slave;
    assign i2c_bit_ctrl   = r_i2c_bc;

endmodule
